// File: rtl/fb_pkg.sv
// Shared types and helpers for the SRAM frame buffer.
package fb_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CAP_W0 = 3'd1,
    S_CAP_W1 = 3'd2,
    S_PB_R0  = 3'd3,
    S_PB_R1  = 3'd4,
    S_PB_OUT = 3'd5,
    S_DONE   = 3'd6
  } fb_state_t;

  localparam logic MODE_CAPTURE  = 1'b0;
  localparam logic MODE_PLAYBACK = 1'b1;

  // Two 16-bit SDRAM words -> {R, G, B}, 8 bits each.
  function automatic logic [23:0] rgb_unpack(input logic [15:0] w0, input logic [15:0] w1);
    return {w1[9:2], w0[14:10], w1[14:12], w0[9:2]};
  endfunction

endpackage

// File: rtl/fb_rgb_unpack.sv
// Pixel unpack with the 8-bit colour left-aligned in the OUT_W display channel.
module fb_rgb_unpack
  import fb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 10
) (
  input  logic [DATA_W-1:0] w0_i,
  input  logic [DATA_W-1:0] w1_i,
  output logic [OUT_W-1:0]  red_o,
  output logic [OUT_W-1:0]  green_o,
  output logic [OUT_W-1:0]  blue_o
);

  logic [23:0] rgb;

  assign rgb     = rgb_unpack(w0_i[15:0], w1_i[15:0]);
  assign red_o   = {rgb[23:16], {(OUT_W-8){1'b0}}};
  assign green_o = {rgb[15:8],  {(OUT_W-8){1'b0}}};
  assign blue_o  = {rgb[7:0],   {(OUT_W-8){1'b0}}};

endmodule

// File: rtl/sram_frame_buffer.sv
// Captures a window of live pixels into SRAM and plays it back to the display.
//
// state    | meaning
// S_IDLE   | live gated pass-through, waiting for start
// S_CAP_W0 | ready for a live pixel; previous pixel's second word on the bus
// S_CAP_W1 | first word of the accepted pixel on the bus
// S_PB_R0  | read address of word 0 on the bus
// S_PB_R1  | read address of word 1 on the bus, word 0 returning
// S_PB_OUT | word 1 returning, then pixel held until the display takes it
// S_DONE   | frame finished, done pulse follows
module sram_frame_buffer
  import fb_pkg::*;
#(
  parameter int H_ACTIVE   = 800,
  parameter int CAP_LINES  = 16,
  parameter int LIVE_LINES = 64,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_loop,
  input  logic              i_abort,
  input  logic              i_pix_valid,
  input  logic [DATA_W-1:0] i_sdram_data_1,
  input  logic [DATA_W-1:0] i_sdram_data_2,
  input  logic [12:0]       i_v_cont,
  output logic              o_pix_ready,
  output logic              o_ccd_pause,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic              o_sram_oe,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_disp_valid,
  input  logic              i_disp_ready,
  output logic [OUT_W-1:0]  o_display_red,
  output logic [OUT_W-1:0]  o_display_green,
  output logic [OUT_W-1:0]  o_display_blue,
  output logic              o_busy,
  output logic              o_done
);

  // One extra bit so a frame filling the whole address space still terminates.
  localparam logic [ADDR_W:0] FRAME_WORDS = (ADDR_W+1)'(2 * H_ACTIVE * CAP_LINES);
  localparam logic [12:0]     LIVE_LIM    = 13'(LIVE_LINES);

  fb_state_t         state_q;
  logic [ADDR_W-1:0] addr_q, sram_addr_q;
  logic [DATA_W-1:0] wdata_q, w0_q, w1_q;
  logic              we_n_q, oe_q, pause_q, pix_ready_q, disp_valid_q, busy_q, done_q;
  logic [OUT_W-1:0]  red_q, green_q, blue_q;
  logic [OUT_W-1:0]  red_d, green_d, blue_d;

  logic [ADDR_W:0]   addr_sum;
  logic              frame_end, pb_state, live_en;
  logic [DATA_W-1:0] unp_w0, unp_w1;
  logic [OUT_W-1:0]  unp_red, unp_green, unp_blue;

  assign addr_sum  = {1'b0, addr_q} + (ADDR_W+1)'(2);
  assign frame_end = (addr_sum == FRAME_WORDS);
  assign pb_state  = (state_q == S_PB_R0) || (state_q == S_PB_R1) || (state_q == S_PB_OUT);
  assign live_en   = (i_v_cont < LIVE_LIM);

  // Playback unpacks the latched word 0 with word 1 straight off the read bus.
  assign unp_w0 = pb_state ? w0_q : i_sdram_data_1;
  assign unp_w1 = pb_state ? i_sram_rdata : i_sdram_data_2;

  fb_rgb_unpack #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_unpack (
    .w0_i    (unp_w0),
    .w1_i    (unp_w1),
    .red_o   (unp_red),
    .green_o (unp_green),
    .blue_o  (unp_blue)
  );

  // Colour next-value: stored pixel in playback, gated live pixel otherwise.
  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pb_state) begin
      if (state_q == S_PB_OUT && !disp_valid_q) begin
        red_d   = unp_red;
        green_d = unp_green;
        blue_d  = unp_blue;
      end
    end else if (live_en) begin
      red_d   = unp_red;
      green_d = unp_green;
      blue_d  = unp_blue;
    end else begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Colour output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  // Sequencer with registered SRAM, handshake and status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      sram_addr_q  <= '0;
      wdata_q      <= '0;
      w0_q         <= '0;
      w1_q         <= '0;
      we_n_q       <= 1'b1;
      oe_q         <= 1'b0;
      pause_q      <= 1'b0;
      pix_ready_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (i_abort) begin
      state_q      <= S_IDLE;
      we_n_q       <= 1'b1;
      oe_q         <= 1'b0;
      pause_q      <= 1'b0;
      pix_ready_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            addr_q      <= '0;
            sram_addr_q <= '0;
            busy_q      <= 1'b1;
            if (i_mode == MODE_PLAYBACK) begin
              state_q <= S_PB_R0;
            end else begin
              state_q     <= S_CAP_W0;
              pix_ready_q <= 1'b1;
            end
          end
        end
        S_CAP_W0: begin
          if (i_pix_valid) begin
            w1_q        <= i_sdram_data_2;
            sram_addr_q <= addr_q;
            wdata_q     <= i_sdram_data_1;
            we_n_q      <= 1'b0;
            oe_q        <= 1'b1;
            pix_ready_q <= 1'b0;
            state_q     <= S_CAP_W1;
          end
        end
        S_CAP_W1: begin
          sram_addr_q <= addr_q + ADDR_W'(1);
          wdata_q     <= w1_q;
          we_n_q      <= 1'b0;
          oe_q        <= 1'b1;
          pause_q     <= 1'b1;
          addr_q      <= addr_sum[ADDR_W-1:0];
          if (frame_end) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_CAP_W0;
            pix_ready_q <= 1'b1;
          end
        end
        S_PB_R0: begin
          sram_addr_q <= addr_q + ADDR_W'(1);
          state_q     <= S_PB_R1;
        end
        S_PB_R1: begin
          w0_q    <= i_sram_rdata;
          state_q <= S_PB_OUT;
        end
        S_PB_OUT: begin
          if (!disp_valid_q) begin
            disp_valid_q <= 1'b1;
          end else if (i_disp_ready) begin
            disp_valid_q <= 1'b0;
            if (frame_end && !i_loop) begin
              addr_q  <= addr_sum[ADDR_W-1:0];
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end else begin
              addr_q      <= frame_end ? '0 : addr_sum[ADDR_W-1:0];
              sram_addr_q <= frame_end ? '0 : addr_sum[ADDR_W-1:0];
              state_q     <= S_PB_R0;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_pix_ready     = pix_ready_q;
  assign o_ccd_pause     = pause_q;
  assign o_sram_addr     = sram_addr_q;
  assign o_sram_we_n     = we_n_q;
  assign o_sram_oe       = oe_q;
  assign o_sram_wdata    = wdata_q;
  assign o_disp_valid    = disp_valid_q;
  assign o_display_red   = red_q;
  assign o_display_green = green_q;
  assign o_display_blue  = blue_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;

endmodule

// File: tb/tb_sram_frame_buffer.sv
// Directed-plus-random bench for sram_frame_buffer with a small SRAM model.
module tb_sram_frame_buffer;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int OW = 10;
  localparam int NPIX = 8;
  localparam int NWORD = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          i_rst = 1'b1, i_start = 1'b0, i_mode = 1'b0, i_loop = 1'b0, i_abort = 1'b0;
  logic          i_pix_valid = 1'b0, i_disp_ready = 1'b0;
  logic [DW-1:0] i_sdram_data_1 = '0, i_sdram_data_2 = '0;
  logic [12:0]   i_v_cont = '0;
  logic [DW-1:0] sram_rdata = '0;
  logic          o_pix_ready, o_ccd_pause, o_sram_we_n, o_sram_oe, o_disp_valid, o_busy, o_done;
  logic [AW-1:0] o_sram_addr;
  logic [DW-1:0] o_sram_wdata;
  logic [OW-1:0] o_display_red, o_display_green, o_display_blue;
  logic [29:0]   disp;

  assign disp = {o_display_red, o_display_green, o_display_blue};

  sram_frame_buffer #(
    .H_ACTIVE(4), .CAP_LINES(2), .LIVE_LINES(64), .ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)
  ) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_loop(i_loop),
    .i_abort(i_abort), .i_pix_valid(i_pix_valid), .i_sdram_data_1(i_sdram_data_1),
    .i_sdram_data_2(i_sdram_data_2), .i_v_cont(i_v_cont), .o_pix_ready(o_pix_ready),
    .o_ccd_pause(o_ccd_pause), .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n),
    .o_sram_oe(o_sram_oe), .o_sram_wdata(o_sram_wdata), .i_sram_rdata(sram_rdata),
    .o_disp_valid(o_disp_valid), .i_disp_ready(i_disp_ready), .o_display_red(o_display_red),
    .o_display_green(o_display_green), .o_display_blue(o_display_blue), .o_busy(o_busy),
    .o_done(o_done)
  );

  // SRAM model: write on we_n low, read data one cycle after the address.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (!o_sram_we_n) mem[o_sram_addr[5:0]] <= o_sram_wdata;
    sram_rdata <= mem[o_sram_addr[5:0]];
  end

  int done_cnt = 0;
  int pause_cnt = 0;
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_ccd_pause) pause_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected display word from the colour rules, using plain arithmetic.
  function automatic logic [29:0] ref_pix(input logic [15:0] w0, input logic [15:0] w1);
    int r, g, b;
    r = (int'(w1) / 4) % 256;
    g = ((int'(w0) / 1024) % 32) * 8 + (int'(w1) / 4096) % 8;
    b = (int'(w0) / 4) % 256;
    return {10'(r * 4), 10'(g * 4), 10'(b * 4)};
  endfunction

  task automatic chk_reset(input string pfx);
    chk({pfx, "_addr"}, 32'(o_sram_addr), 0);
    chk({pfx, "_we_n"}, 32'(o_sram_we_n), 1);
    chk({pfx, "_oe"}, 32'(o_sram_oe), 0);
    chk({pfx, "_pause"}, 32'(o_ccd_pause), 0);
    chk({pfx, "_pix_ready"}, 32'(o_pix_ready), 0);
    chk({pfx, "_disp_valid"}, 32'(o_disp_valid), 0);
    chk({pfx, "_busy"}, 32'(o_busy), 0);
    chk({pfx, "_done"}, 32'(o_done), 0);
    chk({pfx, "_colour"}, 32'(disp), 0);
  endtask

  task automatic do_start(input logic mode);
    i_mode = mode;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!o_disp_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(o_disp_valid), 1);
  endtask

  logic [15:0] cw0 [NPIX];
  logic [15:0] cw1 [NPIX];
  logic [15:0] nw0 [NPIX];
  logic [15:0] nw1 [NPIX];

  // Take one playback pixel: wait, compare colour and read address, then handshake.
  task automatic pb_take(input int k, input string tag);
    int p;
    p = k % NPIX;
    wait_valid({tag, "_valid"});
    chk({tag, "_colour"}, 32'(disp), 32'(ref_pix(cw0[p], cw1[p])));
    chk({tag, "_addr"}, 32'(o_sram_addr), 32'(2 * p + 1));
    i_disp_ready = 1'b1;
    step();
    i_disp_ready = 1'b0;
    chk({tag, "_drop"}, 32'(o_disp_valid), 0);
  endtask

  initial begin
    int k, n, nw, cyc, first_w, last_w, done_cyc, d0, p0;
    logic rdy;
    logic [29:0] held;
    logic [AW-1:0] wa [32];
    logic [DW-1:0] wd [32];
    logic          wp [32];

    // Reset
    step();
    step();
    chk_reset("rst");

    // Live gating, directed vectors from the colour rules and the row boundary
    i_rst = 1'b0;
    i_v_cont = 13'd10;
    i_sdram_data_1 = 16'h7C3C;
    i_sdram_data_2 = 16'h53FC;
    step();
    chk("live_red", 32'(o_display_red), 32'h3FC);
    chk("live_green", 32'(o_display_green), 32'h3F4);
    chk("live_blue", 32'(o_display_blue), 32'h03C);
    i_v_cont = 13'd64;
    step();
    chk("live_row64", 32'(disp), 0);
    i_v_cont = 13'd63;
    step();
    chk("live_row63", 32'(disp), 32'(ref_pix(16'h7C3C, 16'h53FC)));
    for (int i = 0; i < 10; i++) begin
      i_v_cont = 13'($urandom_range(0, 127));
      i_sdram_data_1 = 16'($urandom);
      i_sdram_data_2 = 16'($urandom);
      step();
      chk($sformatf("live_rand%0d", i), 32'(disp),
          (i_v_cont < 64) ? 32'(ref_pix(i_sdram_data_1, i_sdram_data_2)) : 0);
    end

    // Capture one frame with continuous valid
    for (int i = 0; i < NPIX; i++) begin
      cw0[i] = 16'($urandom);
      cw1[i] = 16'($urandom);
    end
    i_v_cont = 13'd100;
    d0 = done_cnt;
    p0 = pause_cnt;
    do_start(1'b0);
    chk("cap_busy", 32'(o_busy), 1);
    chk("cap_ready", 32'(o_pix_ready), 1);
    i_pix_valid = 1'b1;
    k = 0; nw = 0; cyc = 0; first_w = -1; last_w = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < 100) begin
      i_sdram_data_1 = cw0[(k < NPIX) ? k : NPIX - 1];
      i_sdram_data_2 = cw1[(k < NPIX) ? k : NPIX - 1];
      rdy = o_pix_ready;
      step();
      cyc++;
      if (rdy) k++;
      if (!o_sram_we_n && nw < 32) begin
        wa[nw] = o_sram_addr;
        wd[nw] = o_sram_wdata;
        wp[nw] = o_ccd_pause;
        if (first_w < 0) first_w = cyc;
        last_w = cyc;
        nw++;
      end
      if (o_done) done_cyc = cyc;
    end
    i_pix_valid = 1'b0;
    chk("cap_nwrites", 32'(nw), NWORD);
    for (int i = 0; i < NWORD && i < nw; i++) begin
      chk($sformatf("cap_addr%0d", i), 32'(wa[i]), 32'(i));
      chk($sformatf("cap_data%0d", i), 32'(wd[i]),
          32'((i % 2 == 1) ? cw1[i / 2] : cw0[i / 2]));
      chk($sformatf("cap_pause%0d", i), 32'(wp[i]), 32'(i % 2));
    end
    chk("cap_span", 32'(last_w - first_w), NWORD - 1);
    chk("cap_done_cycle", 32'(done_cyc), 32'(last_w + 1));
    step();
    chk("cap_done_width", 32'(o_done), 0);
    chk("cap_done_count", 32'(done_cnt - d0), 1);
    chk("cap_pause_count", 32'(pause_cnt - p0), NPIX);
    chk("cap_idle_busy", 32'(o_busy), 0);
    chk("cap_mem5", 32'(mem[5]), 32'(cw1[2]));

    // Playback, display stalls the first pixel for three cycles
    d0 = done_cnt;
    i_loop = 1'b0;
    do_start(1'b1);
    wait_valid("pb_first_valid");
    held = disp;
    chk("pb_pix0", 32'(held), 32'(ref_pix(cw0[0], cw1[0])));
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("pb_hold_valid%0d", i), 32'(o_disp_valid), 1);
      chk($sformatf("pb_hold_colour%0d", i), 32'(disp), 32'(held));
      chk($sformatf("pb_hold_addr%0d", i), 32'(o_sram_addr), 1);
    end
    for (int i = 0; i < NPIX; i++) pb_take(i, $sformatf("pb%0d", i));
    n = 0;
    while (done_cnt == d0 && n < 10) begin
      step();
      n++;
    end
    step();
    chk("pb_done_count", 32'(done_cnt - d0), 1);
    chk("pb_end_busy", 32'(o_busy), 0);

    // Looping playback wraps to pixel 0 and never signals done
    d0 = done_cnt;
    i_loop = 1'b1;
    do_start(1'b1);
    for (int i = 0; i < NPIX + 3; i++) pb_take(i, $sformatf("loop%0d", i));
    chk("loop_busy", 32'(o_busy), 1);
    chk("loop_no_done", 32'(done_cnt - d0), 0);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    chk("loop_abort_busy", 32'(o_busy), 0);
    chk("loop_abort_valid", 32'(o_disp_valid), 0);
    i_loop = 1'b0;

    // Abort while the first word of pixel 3 is being written
    for (int i = 0; i < NPIX; i++) begin
      nw0[i] = 16'($urandom);
      nw1[i] = ~cw1[i];
    end
    d0 = done_cnt;
    do_start(1'b0);
    i_pix_valid = 1'b1;
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      i_sdram_data_1 = nw0[k];
      i_sdram_data_2 = nw1[k];
      rdy = o_pix_ready;
      step();
      n++;
      if (rdy) k++;
    end
    chk("abort_pre_addr", 32'(o_sram_addr), 6);
    chk("abort_pre_we_n", 32'(o_sram_we_n), 0);
    i_abort = 1'b1;
    i_pix_valid = 1'b0;
    step();
    i_abort = 1'b0;
    chk("abort_we_n", 32'(o_sram_we_n), 1);
    chk("abort_oe", 32'(o_sram_oe), 0);
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_ready", 32'(o_pix_ready), 0);
    step();
    step();
    step();
    chk("abort_no_done", 32'(done_cnt - d0), 0);
    chk("abort_mem6", 32'(mem[6]), 32'(nw0[3]));
    chk("abort_mem7_kept", 32'(mem[7]), 32'(cw1[3]));
    do_start(1'b0);
    i_pix_valid = 1'b1;
    i_sdram_data_1 = nw0[0];
    i_sdram_data_2 = nw1[0];
    step();
    i_pix_valid = 1'b0;
    chk("restart_addr", 32'(o_sram_addr), 0);
    chk("restart_we_n", 32'(o_sram_we_n), 0);
    chk("restart_data", 32'(o_sram_wdata), 32'(nw0[0]));
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;

    // Start while busy is ignored; reset mid-playback clears everything
    do_start(1'b1);
    wait_valid("busy_valid");
    held = disp;
    i_mode = 1'b0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("busy_start_ready", 32'(o_pix_ready), 0);
    chk("busy_start_valid", 32'(o_disp_valid), 1);
    chk("busy_start_busy", 32'(o_busy), 1);
    chk("busy_start_colour", 32'(disp), 32'(held));
    chk("busy_start_we_n", 32'(o_sram_we_n), 1);
    i_rst = 1'b1;
    step();
    chk_reset("midrst");
    i_rst = 1'b0;
    step();
    chk("post_rst_busy", 32'(o_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
